reset_release_sequencer: RTL and testbench

Releases reset to a set of downstream domains in a fixed order. It is the release-side counterpart of the asynchronously reset register primitive: reset assertion propagates asynchronously to every output, and deassertion is synchronized, stretched, then handed out domain by domain with a ready handshake. It sits at the top of each clock domain and drives the `rst` pins of that domain's async-reset registers.

---
 rtl/reset_seq_pkg.sv | 29 ++
 rtl/reset_sync_chain.sv | 28 ++
 rtl/reset_release_sequencer.sv | 154 +++++++++++++++
 tb/tb_reset_release_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the reset release sequencer and its sync chain.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_STRETCH,
        ST_RELEASE,
        ST_WAIT_ACK,
        ST_DONE
    } reset_seq_state_e;

    localparam int DEF_SYNC_STAGES = 3;
    localparam int DEF_NUM_DOMAINS = 4;
    localparam int DEF_STRETCH_W   = 8;
    localparam int DEF_ACK_TIMEOUT = 255;

    // Width needed to address n domains; a single domain still gets one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width needed to hold the values 0..max_val inclusive.
    function automatic int count_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

    localparam int DEF_IDX_W = idx_width(DEF_NUM_DOMAINS);

endpackage

// File: rtl/reset_sync_chain.sv
// Async-clear, sync-release reset synchronizer: assertion is immediate,
// deassertion emerges after SYNC_STAGES rising edges.
module reset_sync_chain
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    output logic sync_rst_n
);

    logic [SYNC_STAGES-1:0] stages;

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its neighbour's pre-edge value; the async clear sits in the
    // sensitivity list so assertion needs no clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_rst_n = stages[SYNC_STAGES-1];

endmodule

// File: rtl/reset_release_sequencer.sv
// Synchronizes reset release, stretches it, then releases downstream domains
// one at a time in index order with a ready/timeout handshake.
module reset_release_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
    parameter int STRETCH_W   = DEF_STRETCH_W,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [STRETCH_W-1:0]   stretch_cfg,
    input  logic                   sw_rst_req,
    input  logic [NUM_DOMAINS-1:0] dom_ack,
    output logic [NUM_DOMAINS-1:0] dom_rst_n,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err
);

    localparam int IDX_W = idx_width(NUM_DOMAINS);
    localparam int TMO_W = count_width(ACK_TIMEOUT);
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [TMO_W-1:0]     TMO_LIMIT = TMO_W'(ACK_TIMEOUT);
    localparam logic [STRETCH_W-1:0] ONE_LEFT  = STRETCH_W'(1);

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("reset_release_sequencer: SYNC_STAGES must be at least 2");
    end
    if (NUM_DOMAINS < 1) begin : g_bad_num_domains
        $error("reset_release_sequencer: NUM_DOMAINS must be at least 1");
    end

    reset_seq_state_e       state_q, state_d;
    logic [STRETCH_W-1:0]   stretch_q, stretch_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   sync_rst_n;
    logic                   skip_stretch;
    logic                   ack_sel;
    logic                   tmo_hit;

    reset_sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync_rst_n(sync_rst_n)
    );

    // A zero stretch skips the hold phase entirely and releases domain 0
    // on the very next edge.
    assign skip_stretch = (stretch_cfg == '0);
    assign ack_sel      = dom_ack[idx_q];
    assign tmo_hit      = (tmo_q == TMO_LIMIT);

    // NOTE: every variable gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        stretch_d = stretch_q;
        tmo_d     = tmo_q;
        idx_d     = idx_q;
        dom_d     = dom_q;
        err_d     = err_q;

        unique case (state_q)
            ST_SYNC: begin
                if (sync_rst_n) begin
                    idx_d     = '0;
                    stretch_d = stretch_cfg;
                    state_d   = skip_stretch ? ST_RELEASE : ST_STRETCH;
                end
            end
            ST_STRETCH: begin
                if (stretch_q <= ONE_LEFT) begin
                    state_d = ST_RELEASE;
                end else begin
                    stretch_d = stretch_q - 1'b1;
                end
            end
            ST_RELEASE: begin
                dom_d[idx_q] = 1'b1;
                tmo_d        = '0;
                state_d      = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // An ack arriving in the final allowed cycle still wins.
                if (ack_sel || tmo_hit) begin
                    if (!ack_sel) begin
                        err_d = 1'b1;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_RELEASE;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_DONE: begin
                // Soft reset re-enters the stretch phase; the sync chain is
                // already settled and is not re-run.
                if (sw_rst_req) begin
                    dom_d     = '0;
                    idx_d     = '0;
                    stretch_d = stretch_cfg;
                    state_d   = skip_stretch ? ST_RELEASE : ST_STRETCH;
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase

        busy_d = (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SYNC;
            stretch_q <= '0;
            tmo_q     <= '0;
            idx_q     <= '0;
            dom_q     <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            stretch_q <= stretch_d;
            tmo_q     <= tmo_d;
            idx_q     <= idx_d;
            dom_q     <= dom_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign dom_rst_n   = dom_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Self-checking bench for reset_release_sequencer: power-on vector table plus
// hand-built abort, timeout, soft-reset and early-ack sequences.
module tb_reset_release_sequencer;

    localparam int ND  = 4;
    localparam int SW  = 8;
    localparam int TMO = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [SW-1:0] stretch_cfg;
    logic          sw_rst_req;
    logic [ND-1:0] dom_ack;
    logic [ND-1:0] dom_rst_n;
    logic          busy;
    logic          done;
    logic          timeout_err;

    reset_release_sequencer #(
        .SYNC_STAGES(3),
        .NUM_DOMAINS(ND),
        .STRETCH_W  (SW),
        .ACK_TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stretch_cfg(stretch_cfg),
        .sw_rst_req (sw_rst_req),
        .dom_ack    (dom_ack),
        .dom_rst_n  (dom_rst_n),
        .busy       (busy),
        .done       (done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ND-1:0] dom;
        logic          busy;
        logic          done;
        logic          err;
        int            id;
    } exp_t;

    typedef struct {
        logic          rst;
        logic          sw;
        logic [ND-1:0] ack;
        logic [SW-1:0] cfg;
        logic [ND-1:0] dom;
        logic          busy;
        logic          done;
        logic          err;
    } vec_t;

    vec_t vec[18];
    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   step_id  = 0;

    task automatic check(input string name, input int id,
                         input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, want);
        end
    endtask

    // Outputs are compared half a cycle after the edge that produced them.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("dom_rst_n",   mon_e.id, 32'(dom_rst_n),   32'(mon_e.dom));
            check("busy",        mon_e.id, 32'(busy),        32'(mon_e.busy));
            check("done",        mon_e.id, 32'(done),        32'(mon_e.done));
            check("timeout_err", mon_e.id, 32'(timeout_err), 32'(mon_e.err));
        end
    end

    task automatic step(input logic r, input logic sw, input logic [ND-1:0] ack,
                        input logic [SW-1:0] cfg, input logic [ND-1:0] e_dom,
                        input logic e_busy, input logic e_done, input logic e_err);
        exp_t e;
        rst_n       = r;
        sw_rst_req  = sw;
        dom_ack     = ack;
        stretch_cfg = cfg;
        @(posedge clk);
        #1;
        e.dom  = e_dom;
        e.busy = e_busy;
        e.done = e_done;
        e.err  = e_err;
        e.id   = step_id;
        step_id++;
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic sw, input logic [ND-1:0] ack,
                                input logic [SW-1:0] cfg, input logic [ND-1:0] dom,
                                input logic b, input logic d, input logic er);
        vec_t v;
        v.rst = r; v.sw = sw; v.ack = ack; v.cfg = cfg;
        v.dom = dom; v.busy = b; v.done = d; v.err = er;
        return v;
    endfunction

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'hF, 8'd5, 4'h0, 1'b1, 1'b0, 1'b0);
    endtask

    // Row i is the edge i after rst_n rises; hold_sw keeps sw_rst_req high
    // through edge 16, i.e. while the sequencer is still busy.
    task automatic run_vec(input int n, input logic hold_sw);
        for (int i = 0; i < n; i++) begin
            step(vec[i].rst, vec[i].sw | (hold_sw && i <= 16), vec[i].ack, vec[i].cfg,
                 vec[i].dom, vec[i].busy, vec[i].done, vec[i].err);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1);
    end

    initial begin
        logic [ND-1:0] sr_dom [9];
        logic [ND-1:0] e_dom;
        logic [ND-1:0] ack;

        for (int i = 0; i < 9; i++) vec[i] = mk(1, 0, 4'hF, 8'd5, 4'h0, 1, 0, 0);
        vec[9]  = mk(1, 0, 4'hF, 8'd5, 4'h1, 1, 0, 0);
        vec[10] = mk(1, 0, 4'hF, 8'd5, 4'h1, 1, 0, 0);
        vec[11] = mk(1, 0, 4'hF, 8'd5, 4'h3, 1, 0, 0);
        vec[12] = mk(1, 0, 4'hF, 8'd5, 4'h3, 1, 0, 0);
        vec[13] = mk(1, 0, 4'hF, 8'd5, 4'h7, 1, 0, 0);
        vec[14] = mk(1, 0, 4'hF, 8'd5, 4'h7, 1, 0, 0);
        vec[15] = mk(1, 0, 4'hF, 8'd5, 4'hF, 1, 0, 0);
        vec[16] = mk(1, 0, 4'hF, 8'd5, 4'hF, 0, 1, 0);
        vec[17] = mk(1, 0, 4'hF, 8'd5, 4'hF, 0, 1, 0);

        rst_n       = 1'b0;
        sw_rst_req  = 1'b0;
        dom_ack     = 4'hF;
        stretch_cfg = 8'd5;

        // Power-on release with all acks tied high.
        do_reset();
        run_vec(18, 1'b0);

        // Abort mid-handshake: outputs must clear before the next edge.
        do_reset();
        run_vec(12, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_dom_rst_n", step_id, 32'(dom_rst_n), 32'h0);
        check("abort_busy",      step_id, 32'(busy),      32'h1);
        check("abort_done",      step_id, 32'(done),      32'h0);
        @(negedge clk);
        #1;
        do_reset();
        run_vec(18, 1'b0);

        // sw_rst_req held while busy is ignored; a pulse in DONE soft-resets
        // with zero stretch, and a pulse mid-handshake is ignored again.
        do_reset();
        run_vec(18, 1'b1);
        sr_dom = '{4'h0, 4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 4'h7, 4'hF, 4'hF};
        for (int k = 0; k < 9; k++) begin
            step(1'b1, (k == 0) || (k == 4), 4'hF, 8'd0, sr_dom[k], k < 8, k == 8, 1'b0);
        end
        step(1'b1, 1'b0, 4'hF, 8'd0, 4'hF, 1'b0, 1'b1, 1'b0);

        // Ack timeout on domain 1.
        do_reset();
        for (int e = 0; e < 28; e++) begin
            e_dom = (e >= 25) ? 4'hF : (e >= 23) ? 4'h7 : (e >= 11) ? 4'h3 :
                    (e >= 9)  ? 4'h1 : 4'h0;
            step(1'b1, 1'b0, 4'b1101, 8'd5, e_dom, e < 26, e >= 26, e >= 22);
        end
        // Soft reset leaves the sticky error in place.
        step(1'b1, 1'b1, 4'hF, 8'd0, 4'h0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 4'hF, 8'd0, 4'h1, 1'b1, 1'b0, 1'b1);

        // Early acks on domains 2 and 3; domains 0 and 1 handshake late.
        do_reset();
        for (int e = 0; e < 15; e++) begin
            ack = 4'b1100;
            if (e >= 6) ack[0] = 1'b1;
            if (e >= 9) ack[1] = 1'b1;
            e_dom = (e >= 12) ? 4'hF : (e >= 10) ? 4'h7 : (e >= 7) ? 4'h3 :
                    (e >= 4)  ? 4'h1 : 4'h0;
            step(1'b1, 1'b0, ack, 8'd0, e_dom, e < 13, e >= 13, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
